// File: rtl/fwd_hazard_tracker.sv
// Forwarding-select generator and load-use hazard detector that tracks in-flight
// destinations itself. Optional stall counter: define FWD_STALL_CNT_EN.
module fwd_hazard_tracker #(
    parameter int NUM_SRC          = 2,
    parameter int NUM_STAGES       = 3,
    parameter int REG_AW           = 5,
    parameter int LOAD_READY_STAGE = 1,
    localparam int SW              = $clog2(NUM_STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      ex_valid,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_reg_write,
    input  logic                      ex_is_load,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    output logic [NUM_SRC*SW-1:0]     fwd_sel,
    output logic                      load_use_stall,
    output logic [NUM_STAGES-1:0]     stage_valid
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0]               stall_count
`endif
);

    generate
        if (NUM_STAGES < 1 || LOAD_READY_STAGE > NUM_STAGES || NUM_SRC < 1) begin : g_bad_params
            $error("fwd_hazard_tracker: illegal parameter combination");
        end
    endgenerate

    // Entry 0 is EX/MEM (youngest); entry NUM_STAGES-1 is the oldest tracked producer.
    logic [NUM_STAGES-1:0] r_valid;
    logic [NUM_STAGES-1:0] r_wr;
    logic [NUM_STAGES-1:0] r_ld;
    logic [REG_AW-1:0]     r_rd [NUM_STAGES];

    logic [NUM_SRC*SW-1:0] w_sel;
    logic [NUM_SRC-1:0]    w_haz;
    logic [REG_AW-1:0]     w_rs_cur;
    logic                  w_issue;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_sel    = '0;
        w_haz    = '0;
        w_rs_cur = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            w_rs_cur = ex_rs[s*REG_AW +: REG_AW];
            // Scan oldest to youngest so the youngest match is the one that sticks.
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (r_valid[k] && r_wr[k] && (r_rd[k] == w_rs_cur) && (r_rd[k] != '0)) begin
                    w_sel[s*SW +: SW] = SW'(k + 1);
                    w_haz[s]          = r_ld[k] && (k < LOAD_READY_STAGE);
                end
            end
        end
    end

    assign fwd_sel        = w_sel;
    assign load_use_stall = ex_valid & ~flush & (|w_haz);
    assign stage_valid    = r_valid;
    assign w_issue        = ex_valid & ~flush & ~load_use_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the rd array is tiny, so it is reset along with the valid bits
            // to keep simulation free of X on the compare paths.
            r_valid <= '0;
            r_wr    <= '0;
            r_ld    <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_rd[k] <= '0;
            end
        end else if (!hold) begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_wr[k]    <= r_wr[k-1];
                r_ld[k]    <= r_ld[k-1];
                r_rd[k]    <= r_rd[k-1];
            end
            // A stalled, flushed or empty EX slot enters the tracker as a bubble.
            r_valid[0] <= w_issue;
            r_wr[0]    <= ex_reg_write;
            r_ld[0]    <= ex_is_load;
            r_rd[0]    <= ex_rd;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (load_use_stall && !hold && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
